// File: rtl/fifo_word_packer.sv
// ============================================================================
// Module   : fifo_word_packer
// Brief    : Pops lane-wide entries from a byte FIFO and packs LANES of them
//            into one wide word with a keep mask; flush emits partial words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_word_packer #(
    parameter int bW    = 8,
    parameter int LANES = 4,
    parameter int cntW  = $clog2(LANES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  pop,
    input  logic                  empty,
    input  logic [bW-1:0]         popData,
    input  logic                  pushSeen,
    input  logic                  flush,
    output logic [bW*LANES-1:0]   outData,
    output logic [LANES-1:0]      outKeep,
    output logic                  outValid,
    input  logic                  outReady
);

    localparam logic [0:0]      c_FILL  = 1'b0;
    localparam logic [0:0]      c_OUT   = 1'b1;
    localparam logic [cntW-1:0] c_LANES = cntW'(LANES);

    logic [0:0]          r_state;
    logic [cntW-1:0]     r_iss;
    logic [cntW-1:0]     r_cnt;
    logic                r_pend;
    logic                r_fl;
    logic [bW*LANES-1:0] r_data;
    logic [LANES-1:0]    r_keep;

    logic                w_accept;
    logic                w_flush;
    logic [cntW-1:0]     w_cnt_inc;

    assign pop       = !rst && (r_state == c_FILL) && !empty && (r_iss < c_LANES) && !r_fl;
    // The FIFO ignores pop whenever it is pushing in the same cycle.
    assign w_accept  = pop && !pushSeen;
    // A flush arriving this cycle acts immediately so the word leaves one cycle later.
    assign w_flush   = r_fl || flush;
    assign w_cnt_inc = r_cnt + 1'b1;

    assign outData  = r_data;
    assign outKeep  = r_keep;
    assign outValid = (r_state == c_OUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_FILL;
            r_iss   <= '0;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_fl    <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
        end else begin
            if (flush) begin
                r_fl <= 1'b1;
            end
            case (r_state)
                c_FILL: begin
                    r_pend <= w_accept;
                    if (w_accept) begin
                        r_iss <= r_iss + 1'b1;
                    end
                    if (r_pend) begin
                        for (int i = 0; i < LANES; i++) begin
                            if (r_cnt == cntW'(i)) begin
                                r_data[i*bW +: bW] <= popData;
                                r_keep[i]          <= 1'b1;
                            end
                        end
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == c_LANES) begin
                            r_state <= c_OUT;
                        end
                    end else if (w_flush && !w_accept) begin
                        // Nothing captured: drop the request rather than emit an empty word.
                        if (r_cnt != '0) begin
                            r_state <= c_OUT;
                        end else begin
                            r_fl <= 1'b0;
                        end
                    end
                end
                c_OUT: begin
                    r_pend <= 1'b0;
                    if (outReady) begin
                        r_cnt   <= '0;
                        r_iss   <= '0;
                        r_keep  <= '0;
                        r_fl    <= 1'b0;
                        r_state <= c_FILL;
                    end
                end
                default: r_state <= c_FILL;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/fifo_word_packer.md
# fifo_word_packer

Downstream consumer of the byte FIFO. It pops `bW`-bit entries through the FIFO's pop/empty/popData interface and packs `LANES` consecutive entries into one wide word. It presents that word on a valid/ready output with a per-lane keep mask. A `flush` request emits a partially filled word, so trailing bytes do not sit in the packer indefinitely.

## Interface
Parameters:
- `bW`, 8, width of one FIFO entry (lane width).
- `LANES`, 4, entries per output word; must be ≥2.
- `cntW`, $clog2(LANES+1), width of the lane counters.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `pop`  out  1  pop request to FIFO.
- `empty`  in  1  FIFO empty flag.
- `popData`  in  bW  FIFO read data; valid the cycle after an accepted pop.
- `pushSeen`  in  1  copy of the FIFO's `push`. The FIFO ignores `pop` in any cycle where `push` is high.
- `flush`  in  1  single-cycle request to emit the bytes popped so far.
- `outData`  out  bW*LANES  packed word; lane 0 (first popped entry) sits in bits [bW-1:0].
- `outKeep`  out  LANES  lane-valid mask; bit i set means lane i holds data.
- `outValid`  out  1  word available.
- `outReady`  in  1  downstream accepts the word.

## Operation
- States: FILL, OUT. Reset state is FILL.
- Counters:
  - `iss`: pops accepted for the current word, range 0..LANES.
  - `cnt`: lanes captured, range 0..LANES.
  - `pend`: 1-bit register, set when a pop was accepted last cycle.
  - `fl`: 1-bit flush-pending flag.
- `pop` is combinational and equals (state==FILL) && !empty && (iss<LANES) && !fl.
- A pop is accepted when `pop && !pushSeen`. On acceptance, `iss` increments and `pend` is set for the next cycle. A pop issued while `pushSeen` is high is not counted and is simply reissued.
- In a cycle with `pend`=1:
  - `popData` is written into lane `cnt`.
  - `outKeep[cnt]` is set.
  - `cnt` increments.
- FILL → OUT when:
  - the capture makes `cnt`==LANES, or
  - `fl`=1, `pend`=0 and `cnt`>0.
- If `fl`=1, `pend`=0 and `cnt`==0 (nothing to flush): clear `fl` and stay in FILL. No empty word is ever emitted.
- OUT:
  - `outValid`=1; `outData` and `outKeep` are held stable.
  - No pops are issued.
  - On `outReady`: clear `cnt`, `iss`, `outKeep` and `fl`, then return to FILL.
- `flush` handling:
  - `flush` sets `fl` in any state.
  - In FILL, it stops new pops; in-flight data still lands before the partial word is emitted.
  - In OUT, the word being presented already satisfies the flush, so `fl` clears on its handshake.
- Lanes not captured keep their previous contents; downstream must use `outKeep`.
- Reset mid-operation:
  - Clears all state and counters and drops any in-flight entry.
  - An entry the FIFO already popped is lost; this is accepted behaviour.

## Timing
- Reset values: `pop`=0 (forced while `rst`), `outValid`=0, `outData`=0, `outKeep`=0.
- Pop-to-capture latency:
  - A pop accepted in cycle c has its data on `popData` in cycle c+1.
  - That data is captured at the end of cycle c+1.
- Full word from a continuously non-empty FIFO:
  - Pops occur in cycles 0..LANES-1.
  - The last capture happens at the end of cycle LANES.
  - `outValid` rises in cycle LANES+1.
- `outValid` stays high until a cycle with `outReady`=1. Pops resume in the following cycle.
- Sustained throughput is LANES entries per LANES+2 cycles (`outReady` tied high).
- `flush` in cycle f with no pop in flight and `cnt`>0: `outValid` rises in cycle f+1. With a pop in flight: `outValid` rises in cycle f+2.
- `pop` never asserts while `empty`=1, so the FIFO never underflows.

## Test plan
- FIFO preloaded with 0x11,0x22,0x33,0x44, `outReady`=1:
  - pops occur in cycles 0..3;
  - cycle 5 shows `outData`=0x44332211, `outKeep`=4'hF;
  - `pop` is next high in cycle 6 (FIFO empty, so it stays 0).
- 0xA1,0xB2 loaded, then `flush` pulsed after both captures: one word with `outData`[15:0]=0xB2A1 and `outKeep`=4'h3, then the block returns to FILL.
- `pushSeen`=1 in the cycle of the 2nd pop: that pop is reissued in the next cycle; bytes arrive in order, `outKeep`=4'hF, and no byte is duplicated or skipped.
- Full word with `outReady`=0 for 10 cycles:
  - `outValid` stays high and `outData` is stable;
  - `pop` stays 0 while the FIFO holds more data;
  - accept in cycle 10, then popping resumes in cycle 11.
- `flush` with `cnt`=0 and FIFO empty: no `outValid` pulse, `fl` clears. `flush` during OUT: exactly one word is emitted and no extra partial word follows.
- `rst` asserted with 2 lanes captured and one pop in flight: the next cycle shows `outValid`=0, `outKeep`=0, `outData`=0, `pop`=0; the next full word starts at lane 0.
